// File: rtl/alu_sequencer.sv
// Command sequencer for the 8-bit accumulator ALU: queues commands, drives the ALU
// selectors/operands, samples the result after LAT cycles and returns it over valid/ready.
module alu_sequencer #(
    parameter int WIDTH      = 8,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic [2:0]       alu_in_selector,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_selector,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_state,
    output logic             busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(LAT + 1) + 1;
    localparam logic [2:0] OP_CLEAR = 3'd7;
    localparam logic [2:0] IN_PERSIST = 3'b001;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_RESET   = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    logic [2:0]       mem_op    [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_a     [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_b     [FIFO_DEPTH];
    logic             mem_chain [FIFO_DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q, num1_q, num2_q, rsp_data_q;
    logic             rsp_valid_q, rsp_error_q;

    logic             full, nonempty, push, pop, sample, sample_err;
    logic [WIDTH-1:0] sample_data;
    logic [6:0]       op_onehot;

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign nonempty  = (count_q != '0);
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == S_IDLE) && nonempty && !rsp_valid_q;
    assign cmd_ready = !full;

    // Head is read combinationally so the pop edge can load operands straight away.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr_q]    <= cmd_op;
            mem_a[wr_ptr_q]     <= cmd_a;
            mem_b[wr_ptr_q]     <= cmd_b;
            mem_chain[wr_ptr_q] <= cmd_chain;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign op_onehot   = (op_q == OP_CLEAR) ? 7'd0 : (7'b1 << op_q);
    assign sample      = (state_q == S_WAIT) && (cnt_q == CW'(LAT));
    assign sample_data = (op_q == OP_CLEAR) ? '0 : alu_result;
    assign sample_err  = (op_q != OP_CLEAR) && (alu_state == 2'b11);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        alu_in_selector  = IN_PERSIST;
        alu_out_selector = 7'd0;
        case (state_q)
            S_IDLE: begin
                if (nonempty && !rsp_valid_q) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                alu_in_selector  = (op_q == OP_CLEAR) ? IN_RESET : IN_LOAD;
                alu_out_selector = op_onehot;
                state_d          = S_WAIT;
                cnt_d            = CW'(1);
            end
            S_WAIT: begin
                alu_out_selector = op_onehot;
                if (cnt_q == CW'(LAT)) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= 3'd0;
            acc_q       <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                op_q   <= mem_op[rd_ptr_q];
                num1_q <= mem_chain[rd_ptr_q] ? acc_q : mem_a[rd_ptr_q];
                num2_q <= mem_b[rd_ptr_q];
            end
            // An errored result must not seed a chained command.
            if (sample) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= sample_data;
                rsp_error_q <= sample_err;
                acc_q       <= sample_err ? '0 : sample_data;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_num1  = num1_q;
    assign alu_num2  = num2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign busy      = nonempty || (state_q != S_IDLE) || rsp_valid_q;

endmodule
